// File: rtl/pixel_minmax_scan.sv
// rtl/pixel_minmax_scan.sv - per-channel RGB444 min/max scan over a contiguous pixel range
// Reads N pixels from image memory and publishes per-channel max/min atomically at completion.
module pixel_minmax_scan #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_pix,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rdata,
    output logic [11:0]       max,
    output logic [11:0]       min,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_N = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_rd_valid;
    logic [11:0]       r_acc_max;
    logic [11:0]       r_acc_min;
    logic [11:0]       r_max;
    logic [11:0]       r_min;
    logic [11:0]       w_upd_max;
    logic [11:0]       w_upd_min;
    logic              w_last;

    // r_remain counts reads still to issue after the current one
    assign w_last = (r_remain == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (num_pix == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Independent unsigned compare per 4-bit colour channel
    always_comb begin
        w_upd_max = r_acc_max;
        w_upd_min = r_acc_min;
        if (r_rd_valid) begin
            for (int c = 0; c < 3; c++) begin
                if (mem_rdata[c*4 +: 4] > r_acc_max[c*4 +: 4]) begin
                    w_upd_max[c*4 +: 4] = mem_rdata[c*4 +: 4];
                end
                if (mem_rdata[c*4 +: 4] < r_acc_min[c*4 +: 4]) begin
                    w_upd_min[c*4 +: 4] = mem_rdata[c*4 +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_rd_valid <= 1'b0;
            r_acc_max  <= 12'h000;
            r_acc_min  <= 12'hFFF;
            r_max      <= 12'hFFF;
            r_min      <= 12'h000;
        end else begin
            r_rd_valid <= (r_state == S_READ);
            case (r_state)
                S_IDLE: begin
                    if (start && (num_pix != '0)) begin
                        r_addr    <= base_addr;
                        r_remain  <= num_pix - ONE_N;
                        r_acc_max <= 12'h000;
                        r_acc_min <= 12'hFFF;
                    end
                end
                S_READ: begin
                    r_acc_max <= w_upd_max;
                    r_acc_min <= w_upd_min;
                    if (!w_last) begin
                        r_addr   <= r_addr + ONE_A;
                        r_remain <= r_remain - ONE_N;
                    end
                end
                S_DRAIN: begin
                    // Final pixel lands this cycle; publish both results together
                    r_acc_max <= w_upd_max;
                    r_acc_min <= w_upd_min;
                    r_max     <= w_upd_max;
                    r_min     <= w_upd_min;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_re   = (r_state == S_READ);
    assign mem_addr = r_addr;
    assign max      = r_max;
    assign min      = r_min;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_pixel_minmax_scan.sv
// tb/tb_pixel_minmax_scan.sv - self-checking bench for pixel_minmax_scan
module tb_pixel_minmax_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] num_pix;
    logic        mem_re;
    logic [13:0] mem_addr;
    logic [11:0] mem_rdata;
    logic [11:0] max_o;
    logic [11:0] min_o;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [11:0] mem [0:16383];
    logic [13:0] exp_addr_q [$];
    logic [23:0] exp_res_q  [$];

    int          s_reads;
    int          s_dones;
    int          s_done_cyc;
    int          s_first_re;
    int          s_busy;
    int          s_early;

    pixel_minmax_scan #(.ADDR_W(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_pix   (num_pix),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .max       (max_o),
        .min       (min_o),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory; garbage on idle cycles so ungated accumulation shows up
    always @(posedge clk) begin
        mem_rdata <= mem_re ? mem[mem_addr] : 12'($urandom);
    end

    function automatic logic [23:0] model(input logic [13:0] b, input int n);
        logic [11:0] mx = 12'h000;
        logic [11:0] mn = 12'hFFF;
        logic [11:0] p;
        for (int k = 0; k < n; k++) begin
            p = mem[b + 14'(k)];
            for (int c = 0; c < 3; c++) begin
                if (p[c*4 +: 4] > mx[c*4 +: 4]) mx[c*4 +: 4] = p[c*4 +: 4];
                if (p[c*4 +: 4] < mn[c*4 +: 4]) mn[c*4 +: 4] = p[c*4 +: 4];
            end
        end
        return {mx, mn};
    endfunction

    // Drives one scan (optionally a stray start at cycle extra_cyc) and scores reads/results
    task automatic do_scan(input logic [13:0] b, input logic [14:0] n, input int extra_cyc);
        logic [11:0] m0;
        logic [11:0] n0;
        logic [13:0] ea;
        logic [23:0] er;
        s_reads = 0; s_dones = 0; s_done_cyc = -1; s_first_re = -1; s_busy = 0; s_early = 0;
        m0 = max_o;
        n0 = min_o;
        @(posedge clk); #1;
        base_addr = b; num_pix = n; start = 1'b1;
        for (int cyc = 1; cyc <= int'(n) + 6; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == extra_cyc);
            @(negedge clk);
            if (mem_re) begin
                s_reads++;
                if (s_first_re < 0) s_first_re = cyc;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL scan_addr unexpected read addr=%h cycle=%0d", mem_addr, cyc);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (mem_addr !== ea) begin
                        failures++;
                        $display("FAIL scan_addr got=%h expected=%h cycle=%0d", mem_addr, ea, cyc);
                    end
                end
            end
            if (busy) s_busy++;
            if (done) begin
                s_dones++;
                if (s_done_cyc < 0) s_done_cyc = cyc;
                checks++;
                if (exp_res_q.size() == 0) begin
                    failures++;
                    $display("FAIL scan_result unexpected done cycle=%0d", cyc);
                end else begin
                    er = exp_res_q.pop_front();
                    if ({max_o, min_o} !== er) begin
                        failures++;
                        $display("FAIL scan_result got max=%h min=%h expected max=%h min=%h",
                                 max_o, min_o, er[23:12], er[11:0]);
                    end
                end
            end else if (s_done_cyc < 0 && (max_o !== m0 || min_o !== n0)) begin
                s_early++;
            end
        end
        start = 1'b0;
        checks++;
        if (exp_addr_q.size() != 0 || exp_res_q.size() != 0) begin
            failures++;
            $display("FAIL scan_missing addr_left=%0d result_left=%0d expected 0",
                     exp_addr_q.size(), exp_res_q.size());
        end
        exp_addr_q.delete();
        exp_res_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; num_pix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (mem_re !== 1'b0)     begin failures++; $display("FAIL reset_mem_re got=%b expected=0", mem_re); end
        if (mem_addr !== 14'h0)  begin failures++; $display("FAIL reset_mem_addr got=%h expected=0000", mem_addr); end
        if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b expected=0", done); end
        if (max_o !== 12'hFFF)   begin failures++; $display("FAIL reset_max got=%h expected=fff", max_o); end
        if (min_o !== 12'h000)   begin failures++; $display("FAIL reset_min got=%h expected=000", min_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem[14'h10] = 12'h123; mem[14'h11] = 12'h9A1; mem[14'h12] = 12'h4F7; mem[14'h13] = 12'h0C2;
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(14'h10 + 14'(k));
        exp_res_q.push_back({12'h9F7, 12'h021});
        do_scan(14'h10, 15'd4, -1);
        checks += 7;
        if (s_reads != 4)     begin failures++; $display("FAIL basic_reads got=%0d expected=4", s_reads); end
        if (s_first_re != 1)  begin failures++; $display("FAIL basic_first_re got=%0d expected=1", s_first_re); end
        if (s_done_cyc != 6)  begin failures++; $display("FAIL basic_done_cycle got=%0d expected=6", s_done_cyc); end
        if (s_dones != 1)     begin failures++; $display("FAIL basic_done_count got=%0d expected=1", s_dones); end
        if (s_busy != 6)      begin failures++; $display("FAIL basic_busy_cycles got=%0d expected=6", s_busy); end
        if (s_early != 0)     begin failures++; $display("FAIL basic_result_early got=%0d expected=0", s_early); end
        if (mem_addr !== 14'h13) begin failures++; $display("FAIL basic_addr_hold got=%h expected=0013", mem_addr); end
    endtask

    task automatic test_zero();
        exp_res_q.push_back({12'h9F7, 12'h021});
        do_scan(14'h20, 15'd0, -1);
        checks += 5;
        if (s_reads != 0)     begin failures++; $display("FAIL zero_reads got=%0d expected=0", s_reads); end
        if (s_done_cyc != 1)  begin failures++; $display("FAIL zero_done_cycle got=%0d expected=1", s_done_cyc); end
        if (s_dones != 1)     begin failures++; $display("FAIL zero_done_count got=%0d expected=1", s_dones); end
        if (s_busy != 1)      begin failures++; $display("FAIL zero_busy_cycles got=%0d expected=1", s_busy); end
        if (mem_addr !== 14'h13) begin failures++; $display("FAIL zero_addr_hold got=%h expected=0013", mem_addr); end
    endtask

    task automatic test_single();
        mem[14'h200] = 12'h5A3;
        exp_addr_q.push_back(14'h200);
        exp_res_q.push_back({12'h5A3, 12'h5A3});
        do_scan(14'h200, 15'd1, -1);
        checks += 3;
        if (s_reads != 1)     begin failures++; $display("FAIL single_reads got=%0d expected=1", s_reads); end
        if (s_done_cyc != 3)  begin failures++; $display("FAIL single_done_cycle got=%0d expected=3", s_done_cyc); end
        if (s_early != 0)     begin failures++; $display("FAIL single_result_early got=%0d expected=0", s_early); end
    endtask

    task automatic test_wrap();
        mem[14'h3FFE] = 12'h8F1; mem[14'h3FFF] = 12'h2B6; mem[14'h0000] = 12'hC0E;
        exp_addr_q.push_back(14'h3FFE);
        exp_addr_q.push_back(14'h3FFF);
        exp_addr_q.push_back(14'h0000);
        exp_res_q.push_back({12'hCFE, 12'h201});
        do_scan(14'h3FFE, 15'd3, -1);
        checks += 2;
        if (s_reads != 3)     begin failures++; $display("FAIL wrap_reads got=%0d expected=3", s_reads); end
        if (s_done_cyc != 5)  begin failures++; $display("FAIL wrap_done_cycle got=%0d expected=5", s_done_cyc); end
    endtask

    task automatic test_start_ignored(input int extra_cyc);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(14'h10 + 14'(k));
        exp_res_q.push_back({12'h9F7, 12'h021});
        do_scan(14'h10, 15'd4, extra_cyc);
        checks += 3;
        if (s_reads != 4)     begin failures++; $display("FAIL start_ignored_reads cyc=%0d got=%0d expected=4", extra_cyc, s_reads); end
        if (s_dones != 1)     begin failures++; $display("FAIL start_ignored_dones cyc=%0d got=%0d expected=1", extra_cyc, s_dones); end
        if (s_done_cyc != 6)  begin failures++; $display("FAIL start_ignored_done_cycle cyc=%0d got=%0d expected=6", extra_cyc, s_done_cyc); end
    endtask

    task automatic test_reset_mid();
        logic [13:0] ea;
        int          stray;
        for (int k = 0; k < 8; k++) mem[14'h100 + 14'(k)] = 12'h111 * 12'(k + 1);
        for (int k = 0; k < 3; k++) exp_addr_q.push_back(14'h100 + 14'(k));
        @(posedge clk); #1;
        base_addr = 14'h100; num_pix = 15'd8; start = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 3) rst = 1'b1;
            @(negedge clk);
            checks++;
            if (!mem_re || exp_addr_q.size() == 0) begin
                failures++;
                $display("FAIL reset_mid_read cycle=%0d mem_re=%b expected=1", cyc, mem_re);
            end else begin
                ea = exp_addr_q.pop_front();
                if (mem_addr !== ea) begin
                    failures++;
                    $display("FAIL reset_mid_addr got=%h expected=%h", mem_addr, ea);
                end
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)     begin failures++; $display("FAIL reset_mid_busy got=%b expected=0", busy); end
        if (mem_re !== 1'b0)   begin failures++; $display("FAIL reset_mid_mem_re got=%b expected=0", mem_re); end
        if (done !== 1'b0)     begin failures++; $display("FAIL reset_mid_done got=%b expected=0", done); end
        if (max_o !== 12'hFFF) begin failures++; $display("FAIL reset_mid_max got=%h expected=fff", max_o); end
        if (min_o !== 12'h000) begin failures++; $display("FAIL reset_mid_min got=%h expected=000", min_o); end
        exp_addr_q.delete();
        stray = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            if (done || mem_re || busy) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL reset_mid_quiet got=%0d active cycles expected=0", stray); end
        mem[14'h104] = 12'h456; mem[14'h105] = 12'h567; mem[14'h106] = 12'h678; mem[14'h107] = 12'h789;
        for (int k = 4; k < 8; k++) exp_addr_q.push_back(14'h100 + 14'(k));
        exp_res_q.push_back({12'h789, 12'h456});
        do_scan(14'h104, 15'd4, -1);
        checks += 2;
        if (s_dones != 1)    begin failures++; $display("FAIL reset_mid_rescan_dones got=%0d expected=1", s_dones); end
        if (s_done_cyc != 6) begin failures++; $display("FAIL reset_mid_rescan_done_cycle got=%0d expected=6", s_done_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [13:0] b;
        int          n;
        for (int t = 0; t < 6; t++) begin
            b = 14'($urandom);
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++) begin
                mem[b + 14'(k)] = 12'($urandom);
                exp_addr_q.push_back(b + 14'(k));
            end
            exp_res_q.push_back(model(b, n));
            do_scan(b, 15'(n), -1);
            checks += 2;
            if (s_reads != n)        begin failures++; $display("FAIL b2b_reads run=%0d got=%0d expected=%0d", t, s_reads, n); end
            if (s_done_cyc != n + 2) begin failures++; $display("FAIL b2b_done_cycle run=%0d got=%0d expected=%0d", t, s_done_cyc, n + 2); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_pix = '0;
        test_reset();
        test_basic();
        test_zero();
        test_single();
        test_wrap();
        test_start_ignored(2);
        test_start_ignored(6);
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_minmax_scan.md
PIXEL_MINMAX_SCAN -- requirements
Module: pixel_minmax_scan

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, giving the image-memory pixel address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a scan request sampled only in IDLE.
REQ-005 SHALL have port base_addr, input, ADDR_W, the first pixel address, latched on accepted start.
REQ-006 SHALL have port num_pix, input, ADDR_W+1, the pixel count N, latched on accepted start; 0 is legal.
REQ-007 SHALL have port mem_re, output, 1, the image-memory read enable.
REQ-008 SHALL have port mem_addr, output, ADDR_W, the read address, meaningful when mem_re=1.
REQ-009 SHALL have port mem_rdata, input, 12, an RGB444 pixel {R[11:8],G[7:4],B[3:0]}, valid exactly one cycle after the mem_re cycle.
REQ-010 SHALL have port max, output, 12, the per-channel maximum of the last completed scan; it feeds the pixel ALU max input.
REQ-011 SHALL have port min, output, 12, the per-channel minimum of the last completed scan; it feeds the pixel ALU min input.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-015 IDLE with start=1 and num_pix>0 SHALL latch the inputs, set accumulators acc_max=12'h000 and acc_min=12'hFFF, and go to READ.
REQ-016 IDLE with start=1 and num_pix=0 SHALL go to DONE directly; max and min SHALL remain unchanged.
REQ-017 In READ, mem_re SHALL be 1 every cycle, with mem_addr=base_addr+k for k=0..N-1, one per cycle, with no gaps.
REQ-018 READ SHALL move to DRAIN after the cycle issuing k=N-1.
REQ-019 Address arithmetic SHALL wrap modulo 2^ADDR_W (for example, base_addr=2^ADDR_W-1 is followed by 0).
REQ-020 SHALL keep an internal rd_valid flag that is the previous cycle's mem_re; mem_rdata SHALL be accumulated only when rd_valid=1.
REQ-021 Accumulation SHALL run independently per 4-bit channel with unsigned compares: acc_max.ch=max(acc_max.ch,pix.ch) and acc_min.ch=min(acc_min.ch,pix.ch).
REQ-022 DRAIN SHALL last one cycle, absorb the final pixel, and then go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 On the edge entering DONE from DRAIN, max and min SHALL load acc_max and acc_min atomically, so they are stable during a scan.
REQ-025 Latency SHALL be as follows, taking cycle 0 as the cycle in which start is sampled high: mem_re is high in cycles 1..N, and done, max and min update are visible in cycle N+2.
REQ-026 For N=0, done SHALL be high in cycle 1.
REQ-027 start while busy=1 SHALL be ignored, with no queueing.
REQ-028 start in the DONE cycle SHALL be ignored.
REQ-029 mem_re SHALL be 0 in IDLE, DRAIN and DONE.
REQ-030 mem_addr SHALL hold its last value when mem_re=0.

Reset
REQ-031 rst=1 SHALL force state=IDLE, mem_re=0, mem_addr=0, busy=0, done=0, rd_valid=0, max=12'hFFF and min=12'h000.
REQ-032 rst asserted mid-scan SHALL abort the scan, apply the REQ-031 values on the next edge, and produce no done pulse.
REQ-033 Read data returning after reset SHALL be discarded.
REQ-034 rst SHALL have priority over start in the same cycle.

Verification
REQ-035 Scenario, basic scan: base_addr=0x0010, N=4, memory 0x123,0x9A1,0x4F7,0x0C2 -> mem_re cycles 1-4 with addresses 0x10-0x13; done in cycle 6 with max=0x9F7 and min=0x021.
REQ-036 Scenario, single pixel: N=1, pixel 0x5A3 -> done in cycle 3 with max=min=0x5A3.
REQ-037 Scenario, zero count: N=0 after a prior scan gave max=0x9F7 -> done in cycle 1, mem_re never high, max and min unchanged.
REQ-038 Scenario, wrap-around: base_addr=0x3FFE, N=3 -> addresses 0x3FFE, 0x3FFF, 0x0000.
REQ-039 Scenario, start during busy: a second start in cycle 2 of an N=4 scan -> ignored, exactly one done, exactly 4 reads.
REQ-040 Scenario, reset mid-scan: rst in cycle 3 of an N=8 scan -> next cycle idle, max=0xFFF, min=0x000, no done; a new start then runs cleanly.
